// File: rtl/data_memory_pipelined.sv
// Word-organised byte-addressable data memory with a valid/ready request channel,
// a READ_LATENCY-deep response pipeline with backpressure, RV32 load/store shaping and fault flags.
module data_memory_pipelined #(
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1,
  parameter bit CHECK_RANGE  = 1'b1
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [31:0] i_ReqAddress,
  input  logic [31:0] i_ReqData,
  input  logic [2:0]  i_ReqMode,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic [31:0] o_RespData,
  output logic        o_RespMisaligned,
  output logic        o_RespBadMode,
  output logic        o_RespAccessFault
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  mode;
    logic [1:0]  lane;
    logic        bad_mode;
    logic        misaligned;
    logic        access_fault;
    logic [31:0] word;
  } stage_t;

  stage_t      stage_q [READ_LATENCY];
  stage_t      stage_d [READ_LATENCY];
  logic [31:0] mem_q   [DEPTH];

  logic             mem_we_d;
  logic [31:0]      mem_wdata_d;
  logic [IDX_W-1:0] req_idx_s;
  logic             range_fault_s;
  logic             bad_raw_s;
  logic             mis_raw_s;
  logic             bad_mode_s;
  logic             misaligned_s;
  logic             access_fault_s;
  logic             stall_s;
  logic             accept_s;
  stage_t           last_s;

  function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wdata,
                                              input logic [2:0] mode, input logic [1:0] lane);
    logic [31:0] w;
    w = old_word;
    case (mode[1:0])
      2'b00:   w[{lane, 3'b000} +: 8]       = wdata[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16]  = wdata[15:0];
      2'b10:   w = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] mode,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (mode)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  generate
    if (CHECK_RANGE && (ADDR_WIDTH < 32)) begin : g_range
      assign range_fault_s = |i_ReqAddress[31:ADDR_WIDTH];
    end else begin : g_no_range
      assign range_fault_s = 1'b0;
    end
  endgenerate

  assign req_idx_s  = i_ReqAddress[ADDR_WIDTH-1:2];
  assign last_s     = stage_q[READ_LATENCY-1];
  assign stall_s    = last_s.valid && !i_RespReady;
  assign o_ReqReady = !stall_s && !i_Reset;
  assign accept_s   = i_ReqValid && o_ReqReady;

  // Fault decode on the incoming request; only the highest-priority flag survives.
  always_comb begin
    bad_mode_s     = 1'b0;
    misaligned_s   = 1'b0;
    access_fault_s = 1'b0;
    case (i_ReqMode)
      3'b011, 3'b110, 3'b111: bad_raw_s = 1'b1;
      3'b100, 3'b101:         bad_raw_s = i_ReqWrite;
      default:                bad_raw_s = 1'b0;
    endcase
    case (i_ReqMode[1:0])
      2'b01:   mis_raw_s = i_ReqAddress[0];
      2'b10:   mis_raw_s = |i_ReqAddress[1:0];
      default: mis_raw_s = 1'b0;
    endcase
    if (bad_raw_s) begin
      bad_mode_s = 1'b1;
    end else if (mis_raw_s) begin
      misaligned_s = 1'b1;
    end else if (range_fault_s) begin
      access_fault_s = 1'b1;
    end else begin
      access_fault_s = 1'b0;
    end
  end

  // Pipeline advance and RAM write request; every stage holds while the output is stalled.
  always_comb begin
    for (int i = 0; i < READ_LATENCY; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (!stall_s) begin
      stage_d[0].valid        = accept_s;
      stage_d[0].write        = i_ReqWrite;
      stage_d[0].mode         = i_ReqMode;
      stage_d[0].lane         = i_ReqAddress[1:0];
      stage_d[0].bad_mode     = bad_mode_s;
      stage_d[0].misaligned   = misaligned_s;
      stage_d[0].access_fault = access_fault_s;
      stage_d[0].word         = mem_q[req_idx_s];
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d[0] = stage_q[0];
    end
    mem_we_d    = accept_s && i_ReqWrite && !(bad_mode_s || misaligned_s || access_fault_s);
    mem_wdata_d = merge_store(mem_q[req_idx_s], i_ReqData, i_ReqMode, i_ReqAddress[1:0]);
  end

  // Pipeline state registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge i_Clock) begin
    if (mem_we_d) begin
      mem_q[req_idx_s] <= mem_wdata_d;
    end
  end

  // Response shaping from the final stage; everything reads zero without a valid response.
  always_comb begin
    o_RespValid       = last_s.valid;
    o_RespBadMode     = last_s.valid && last_s.bad_mode;
    o_RespMisaligned  = last_s.valid && last_s.misaligned;
    o_RespAccessFault = last_s.valid && last_s.access_fault;
    if (last_s.valid && !last_s.write && !last_s.bad_mode && !last_s.misaligned && !last_s.access_fault) begin
      o_RespData = load_extract(last_s.word, last_s.mode, last_s.lane);
    end else begin
      o_RespData = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: directed vector table, burst/stall and reset sequences,
// then randomized traffic scored against a byte-array reference model.
module tb_data_memory_pipelined;

  localparam int AW  = 15;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ReqValid;
  logic        o_ReqReady;
  logic        i_ReqWrite;
  logic [31:0] i_ReqAddress;
  logic [31:0] i_ReqData;
  logic [2:0]  i_ReqMode;
  logic        o_RespValid;
  logic        i_RespReady;
  logic [31:0] o_RespData;
  logic        o_RespMisaligned;
  logic        o_RespBadMode;
  logic        o_RespAccessFault;
  logic [2:0]  resp_flags;

  logic rand_ready  = 1'b0;
  logic rnd_ready   = 1'b1;
  logic ready_force = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    int          cyc;
    int          stalls;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  m;
    logic [31:0] ed;
    logic [2:0]  ef;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[$];
  logic [7:0] mdl [256];

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int stall_cnt = 0;
  bit front_seen = 1'b0;

  data_memory_pipelined #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CHECK_RANGE(1'b1)) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_ReqValid       (i_ReqValid),
    .o_ReqReady       (o_ReqReady),
    .i_ReqWrite       (i_ReqWrite),
    .i_ReqAddress     (i_ReqAddress),
    .i_ReqData        (i_ReqData),
    .i_ReqMode        (i_ReqMode),
    .o_RespValid      (o_RespValid),
    .i_RespReady      (i_RespReady),
    .o_RespData       (o_RespData),
    .o_RespMisaligned (o_RespMisaligned),
    .o_RespBadMode    (o_RespBadMode),
    .o_RespAccessFault(o_RespAccessFault)
  );

  assign resp_flags  = {o_RespBadMode, o_RespMisaligned, o_RespAccessFault};
  assign i_RespReady = rand_ready ? rnd_ready : ready_force;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Response monitor: in-order scoreboard, latency, idle-zero outputs and ready/stall relation.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("req_ready", 32'(o_ReqReady), 32'(!(o_RespValid && !i_RespReady)));
      if (!o_RespValid) begin
        check("idle_data", o_RespData, 32'h0);
        check("idle_flags", 32'(resp_flags), 32'h0);
      end else if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got data 0x%08h with no request outstanding", o_RespData);
      end else begin
        if (!front_seen) begin
          check("latency", 32'(cyc - expq[0].cyc - (stall_cnt - expq[0].stalls)), 32'(LAT));
          front_seen = 1'b1;
        end
        if (i_RespReady) begin
          check("resp_data", o_RespData, expq[0].data);
          check("resp_flags", 32'(resp_flags), 32'(expq[0].flags));
          void'(expq.pop_front());
          front_seen = 1'b0;
        end
      end
      if (o_RespValid && !i_RespReady) stall_cnt++;
    end
  end

  // Entered at a negedge; holds the request until accepted, returns at the following negedge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                       input logic [31:0] ed, input logic [2:0] ef);
    bit done;
    done = 1'b0;
    i_ReqValid = 1'b1;
    i_ReqWrite = w;
    i_ReqAddress = a;
    i_ReqData = d;
    i_ReqMode = m;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (o_ReqReady) begin
        expq.push_back('{data: ed, flags: ef, cyc: cyc, stalls: stall_cnt});
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: request at 0x%08h never accepted", a);
      i_ReqValid = 1'b0;
    end
  endtask

  task automatic idle();
    i_ReqValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && expq.size() != 0; k++) @(negedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses missing expected 0", expq.size());
      expq.delete();
    end
  endtask

  // Reference: memory as bytes, access size 2**mode[1:0], little-endian gather/scatter.
  task automatic model_op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                          output logic [31:0] ed, output logic [2:0] ef);
    int sz;
    int base;
    bit bad, mis, acc;
    logic [31:0] r;
    bad  = (m == 3'd3) || (m == 3'd6) || (m == 3'd7) || (w && m[2]);
    sz   = 1 << m[1:0];
    mis  = !bad && ((a % sz) != 0);
    acc  = !bad && !mis && (a >= (32'h1 << AW));
    base = int'(a[7:0]);
    ed   = 32'h0;
    ef   = {bad, mis, acc};
    if (!bad && !mis && !acc) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mdl[base + i] = d[8*i +: 8];
      end else begin
        r = 32'h0;
        for (int i = 0; i < sz; i++) r[8*i +: 8] = mdl[base + i];
        if (!m[2] && sz < 4 && r[8*sz-1]) r = r | ~((32'h1 << (8*sz)) - 32'h1);
        ed = r;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ed, d, a;
    logic [2:0]  ef, m;
    logic        w;
    int          st0;

    rst = 1'b1;
    i_ReqValid = 1'b0;
    i_ReqWrite = 1'b0;
    i_ReqAddress = 32'h0;
    i_ReqData = 32'h0;
    i_ReqMode = 3'b010;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(o_RespValid), 32'h0);
    check("rst_data", o_RespData, 32'h0);
    check("rst_flags", 32'(resp_flags), 32'h0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(o_ReqReady), 32'h1);
    @(negedge clk);

    // Directed vectors: {write, addr, data, mode, expected data, expected {bad,mis,acc}}
    tbl.push_back('{1'b1, 32'h100,   32'h8000_00F0, 3'b010, 32'h0,         3'b000});
    tbl.push_back('{1'b0, 32'h100,   32'h0,         3'b000, 32'hFFFF_FFF0, 3'b000});
    tbl.push_back('{1'b0, 32'h100,   32'h0,         3'b100, 32'h0000_00F0, 3'b000});
    tbl.push_back('{1'b0, 32'h102,   32'h0,         3'b001, 32'hFFFF_8000, 3'b000});
    tbl.push_back('{1'b1, 32'h40,    32'h1122_3344, 3'b010, 32'h0,         3'b000});
    tbl.push_back('{1'b1, 32'h41,    32'h0000_00AA, 3'b000, 32'h0,         3'b000});
    tbl.push_back('{1'b1, 32'h42,    32'h0000_BEEF, 3'b001, 32'h0,         3'b000});
    tbl.push_back('{1'b0, 32'h40,    32'h0,         3'b010, 32'hBEEF_AA44, 3'b000});
    tbl.push_back('{1'b0, 32'h40,    32'h0,         3'b001, 32'hFFFF_AA44, 3'b000});
    tbl.push_back('{1'b0, 32'h42,    32'h0,         3'b101, 32'h0000_BEEF, 3'b000});
    tbl.push_back('{1'b0, 32'h41,    32'h0,         3'b000, 32'hFFFF_FFAA, 3'b000});
    tbl.push_back('{1'b0, 32'h43,    32'h0,         3'b100, 32'h0000_00BE, 3'b000});
    tbl.push_back('{1'b1, 32'h4,     32'hCAFE_BABE, 3'b010, 32'h0,         3'b000});
    tbl.push_back('{1'b0, 32'h6,     32'h0,         3'b010, 32'h0,         3'b010});
    tbl.push_back('{1'b0, 32'h3,     32'h0,         3'b001, 32'h0,         3'b010});
    tbl.push_back('{1'b1, 32'h4,     32'h0000_0055, 3'b100, 32'h0,         3'b100});
    tbl.push_back('{1'b0, 32'h4,     32'h0,         3'b010, 32'hCAFE_BABE, 3'b000});
    tbl.push_back('{1'b0, 32'h6,     32'h0,         3'b001, 32'hFFFF_CAFE, 3'b000});
    tbl.push_back('{1'b0, 32'h6,     32'h0,         3'b101, 32'h0000_CAFE, 3'b000});
    tbl.push_back('{1'b1, 32'h0,     32'h1234_5678, 3'b010, 32'h0,         3'b000});
    tbl.push_back('{1'b1, 32'h1_0000, 32'hDEAD_BEEF, 3'b010, 32'h0,        3'b001});
    tbl.push_back('{1'b0, 32'h0,     32'h0,         3'b010, 32'h1234_5678, 3'b000});
    tbl.push_back('{1'b1, 32'h1,     32'hFFFF_FFFF, 3'b111, 32'h0,         3'b100});
    tbl.push_back('{1'b0, 32'h1_0001, 32'h0,        3'b010, 32'h0,         3'b010});
    tbl.push_back('{1'b0, 32'h1_0002, 32'h0,        3'b101, 32'h0,         3'b001});
    tbl.push_back('{1'b1, 32'h1_0001, 32'h0,        3'b101, 32'h0,         3'b100});
    tbl.push_back('{1'b0, 32'h0,     32'h0,         3'b011, 32'h0,         3'b100});
    for (int i = 0; i < tbl.size(); i++) issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].ed, tbl[i].ef);
    idle();
    drain();

    // Six back-to-back loads with the consumer stalling two cycles mid-burst.
    st0 = stall_cnt;
    fork
      begin
        issue(1'b0, 32'h100, 32'h0, 3'b010, 32'h8000_00F0, 3'b000);
        issue(1'b0, 32'h40,  32'h0, 3'b010, 32'hBEEF_AA44, 3'b000);
        issue(1'b0, 32'h4,   32'h0, 3'b010, 32'hCAFE_BABE, 3'b000);
        issue(1'b0, 32'h0,   32'h0, 3'b010, 32'h1234_5678, 3'b000);
        issue(1'b0, 32'h100, 32'h0, 3'b000, 32'hFFFF_FFF0, 3'b000);
        issue(1'b0, 32'h40,  32'h0, 3'b010, 32'hBEEF_AA44, 3'b000);
        i_ReqValid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        ready_force = 1'b1;
      end
    join
    drain();
    check("burst_stalls", 32'(stall_cnt - st0), 32'h2);

    // Reset with two loads in flight, then a fresh load.
    issue(1'b0, 32'h0, 32'h0, 3'b010, 32'h1234_5678, 3'b000);
    issue(1'b0, 32'h4, 32'h0, 3'b010, 32'hCAFE_BABE, 3'b000);
    i_ReqValid = 1'b0;
    @(negedge clk);
    check("inflight_valid", 32'(o_RespValid), 32'h1);
    ready_force = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_drop_valid", 32'(o_RespValid), 32'h0);
    check("reset_drop_data", o_RespData, 32'h0);
    expq.delete();
    front_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_force = 1'b1;
    #1;
    check("post_reset_ready", 32'(o_ReqReady), 32'h1);
    @(negedge clk);
    issue(1'b0, 32'h0, 32'h0, 3'b010, 32'h1234_5678, 3'b000);
    idle();
    drain();

    // Randomized traffic over bytes 0..255 with occasional out-of-range addresses.
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      model_op(1'b1, 32'(i * 4), d, 3'b010, ed, ef);
      issue(1'b1, 32'(i * 4), d, 3'b010, ed, ef);
    end
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = a | 32'h1_0000;
      m = 3'($urandom_range(0, 7));
      d = $urandom;
      model_op(w, a, d, m, ed, ef);
      issue(w, a, d, m, ed, ef);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
